// File: rtl/muldiv_iter.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with a 1-cycle divide fast path.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [2:0]        opR;
    logic              neg;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;

    logic              signedA, signedB, aNeg, bNeg, negIn;
    logic              divZero, ovf;
    logic [XLEN-1:0]   aMag, bMag, fastRes;

    assign signedA = (op == 3'b001) || (op == 3'b010) ||
                     (op == 3'b100) || (op == 3'b110);
    assign signedB = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign aNeg    = signedA && a[XLEN-1];
    assign bNeg    = signedB && b[XLEN-1];
    assign aMag    = aNeg ? -a : a;
    assign bMag    = bNeg ? -b : b;
    // REM takes the dividend's sign; every other op uses the XOR
    assign negIn   = (op == 3'b110) ? aNeg : (aNeg ^ bNeg);
    assign divZero = op[2] && (b == '0);
    assign ovf     = op[2] && !op[0] && (a == MINV) && (b == '1);
    assign fastRes = divZero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

    logic [XLEN:0]     mulSum, remShift, diff;
    logic [2*XLEN-1:0] mulNext, divNext, accNext, prodFix;
    logic [XLEN-1:0]   quotFix, remFix, finalRes;

    assign mulSum   = {1'b0, acc[2*XLEN-1:XLEN]} +
                      (acc[0] ? {1'b0, opnd} : '0);
    assign mulNext  = {mulSum, acc[XLEN-1:1]};
    assign remShift = acc[2*XLEN-1:XLEN-1];
    assign diff     = remShift - {1'b0, opnd};
    assign divNext  = diff[XLEN] ?
                      {remShift[XLEN-1:0], acc[XLEN-2:0], 1'b0} :
                      {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    assign accNext  = opR[2] ? divNext : mulNext;
    assign prodFix  = neg ? -accNext : accNext;
    assign quotFix  = neg ? -accNext[XLEN-1:0] : accNext[XLEN-1:0];
    assign remFix   = neg ? -accNext[2*XLEN-1:XLEN] : accNext[2*XLEN-1:XLEN];

    always_comb begin
        finalRes = '0;
        case (opR)
            3'b000:                 finalRes = prodFix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: finalRes = prodFix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         finalRes = quotFix;
            default:                finalRes = remFix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            opR    <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            opnd   <= '0;
            acc    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opR <= op;
                        neg <= negIn;
                        if (divZero || ovf) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= fastRes;
                        end else begin
                            state <= BUSY;
                            busy  <= 1'b1;
                            cnt   <= '0;
                            opnd  <= op[2] ? bMag : aMag;
                            acc   <= {{XLEN{1'b0}}, op[2] ? aMag : bMag};
                        end
                    end
                end
                BUSY: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= accNext;
                        cnt <= cnt + 1'b1;
                        // last iteration folds in the sign fix
                        if (cnt == CW'(XLEN-1)) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            result <= finalRes;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule
